wait_state_memory: RTL and testbench
====================================

Name: wait_state_memory

Overview:
- Parametrised successor to the core's flat byte-masked memory.
- Data width, capacity and access latency are configurable.
- Replaces the fire-and-forget strobe interface with a valid/ready request channel and a valid/ready response channel.
- Adds out-of-range error reporting, so the core and its bench can model slow memories and bus faults.

Parameters:
SIZE, 4*1024*1024, capacity in bytes; must be a multiple of DATA_WIDTH/8 and a power of two
DATA_WIDTH, 32, word width in bits; 32 or 64 only
ADDR_WIDTH, 32, request address width in bits; must be >= log2(SIZE)
LATENCY, 0, extra wait cycles before a response (0..15)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_ni  input  1  asynchronous active-low reset
req_valid_i  input  1  request present
req_ready_o  output  1  block can accept a request this cycle
req_addr_i  input  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored
req_wmask_i  input  DATA_WIDTH/8  byte write enables; all-zero means read
req_wdata_i  input  DATA_WIDTH  write data, byte lanes selected by req_wmask_i
rsp_valid_o  output  1  response present
rsp_ready_i  input  1  consumer takes the response this cycle
rsp_rdata_o  output  DATA_WIDTH  read data; zero for writes and errors
rsp_err_o  output  1  request address was >= SIZE

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: state=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, wait counter=0.
- Array contents are NOT cleared by reset. Contents are undefined until written (X in simulation).
- Accept: a request is accepted on a rising edge where req_valid_i && req_ready_o.
- req_ready_o is 1 only in IDLE. It is combinationally derived from state, never from req_valid_i.
- Access timing: on the accept edge the word index is addr[log2(SIZE)-1 : log2(DATA_WIDTH/8)].
  - Write: each byte lane with its mask bit set is written to the array on that same edge.
  - Read: the word is captured into an internal response register on that same edge.
- Error: if req_addr_i >= SIZE, no array write occurs, the captured data is 0 and the captured err is 1.
- FSM:
  - IDLE --accept, LATENCY==0--> RESP
  - IDLE --accept, LATENCY>0--> WAIT; counter loaded with LATENCY-1
  - WAIT: counter decrements each cycle; at 0 --> RESP
  - RESP: rsp_valid_o=1; rsp_rdata_o and rsp_err_o are stable and held until rsp_ready_i=1
  - RESP --rsp_ready_i--> IDLE
- Latency: rsp_valid_o rises exactly LATENCY+1 cycles after the accept edge.
  - Minimum occupancy is LATENCY+2 cycles per transaction; no overlap between transactions.
- Writes also produce one response (rdata=0), used by the core as a write acknowledge.
- Outside RESP, rsp_rdata_o and rsp_err_o are 0.
- Request inputs are ignored outside IDLE: no write, no capture, even if req_valid_i=1.
- Reset mid-operation (WAIT or RESP): state goes to IDLE immediately and rsp_valid_o drops asynchronously. The pending response is lost. A write committed at accept stays committed.
- Read-after-write: a read accepted after a write's response returns the written bytes. Unmasked bytes are unchanged.
- Elaboration: if SIZE, DATA_WIDTH or LATENCY violate the constraints above, raise an error and finish.

Test Plan:
- Reset, then write addr 0x10, mask 4'b1111, data 0xDEADBEEF; then read 0x10 (LATENCY=0) -> write rsp 1 cycle after accept with rdata 0, err 0; read rsp rdata 0xDEADBEEF.
- Write 0x10 mask 4'b0101 data 0x11223344 over 0xDEADBEEF; read 0x13 -> rdata 0xDE22BE44 (low address bits ignored).
- LATENCY=3: read accepted at cycle N -> rsp_valid_o first high at N+4; req_ready_o low for cycles N+1..N+4 while req_valid_i is held high; no second accept.
- Hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o, rdata and err stable throughout; IDLE and req_ready_o=1 the cycle after rsp_ready_i=1.
- SIZE=4096: write 0x1000 mask all-ones data 0xFFFFFFFF, then read 0x0 -> write rsp err=1; read rsp rdata is the prior content of word 0 (write did not alias).
- LATENCY=5: assert rst_ni=0 in WAIT, release, then read the written address -> rsp_valid_o=0 during reset, state IDLE; earlier write still visible; DATA_WIDTH=64 run repeats the first scenario with 8-bit mask.

Source files
------------

// File: rtl/wait_state_memory.sv
// Byte-masked word memory with valid/ready request and response channels,
// a configurable wait-state latency and out-of-range error reporting.
module wait_state_memory #(
    parameter int SIZE       = 4*1024*1024,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LATENCY    = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH/8-1:0] req_wmask_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int BW    = $clog2(NB);
    localparam int MW    = $clog2(SIZE);
    localparam int WORDS = SIZE / NB;
    localparam int IW    = MW - BW;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
        $fatal(1, "wait_state_memory: DATA_WIDTH must be 32 or 64");
    end
    if (SIZE < NB || (SIZE & (SIZE - 1)) != 0) begin : g_bad_size
        $fatal(1, "wait_state_memory: SIZE must be a power of two and >= DATA_WIDTH/8");
    end
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_lat
        $fatal(1, "wait_state_memory: LATENCY must be 0..15");
    end
    if (ADDR_WIDTH < MW) begin : g_bad_aw
        $fatal(1, "wait_state_memory: ADDR_WIDTH must be >= log2(SIZE)");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   mem_q [WORDS];

    logic                    accept;
    logic                    addr_err;
    logic                    is_wr;
    logic [IW-1:0]           idx;

    // SIZE is a power of two, so any set bit at or above log2(SIZE) is out of range.
    assign addr_err = |(req_addr_i >> MW);
    assign is_wr    = |req_wmask_i;
    assign idx      = req_addr_i[MW-1:BW];

    // Array is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (accept && !addr_err) begin
            for (int b = 0; b < NB; b++) begin
                if (req_wmask_i[b]) mem_q[idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready_o = (state_q == S_IDLE);
        accept      = req_ready_o && req_valid_i;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    err_d   = addr_err;
                    rdata_d = (addr_err || is_wr) ? '0 : mem_q[idx];
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
    assign rsp_err_o   = rsp_valid_o && err_q;

endmodule

// File: tb/tb_wait_state_memory.sv
// Scoreboard bench: a 32-bit LATENCY=0 instance and a 64-bit LATENCY=3 instance
// share one stimulus path selected by sel.
module tb_wait_state_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic [15:0] addr;
    logic [7:0]  mask;
    logic [63:0] wdata;
    logic        rsp_ready;

    logic        rdy0, rdy1, rv0, rv1, er0, er1;
    logic [31:0] rd0;
    logic [63:0] rd1;
    logic        rdy, rv, er;
    logic [63:0] rd;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t q[$];

    logic [7:0] mdl [2][4096];

    always #5 clk = ~clk;

    assign rdy = sel ? rdy1 : rdy0;
    assign rv  = sel ? rv1  : rv0;
    assign er  = sel ? er1  : er0;
    assign rd  = sel ? rd1  : {32'h0, rd0};

    wait_state_memory #(.SIZE(4096), .DATA_WIDTH(32), .ADDR_WIDTH(16), .LATENCY(0)) u_d0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid && !sel), .req_ready_o(rdy0),
        .req_addr_i(addr), .req_wmask_i(mask[3:0]), .req_wdata_i(wdata[31:0]),
        .rsp_valid_o(rv0), .rsp_ready_i(rsp_ready && !sel),
        .rsp_rdata_o(rd0), .rsp_err_o(er0)
    );

    wait_state_memory #(.SIZE(4096), .DATA_WIDTH(64), .ADDR_WIDTH(16), .LATENCY(3)) u_d1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid && sel), .req_ready_o(rdy1),
        .req_addr_i(addr), .req_wmask_i(mask), .req_wdata_i(wdata),
        .rsp_valid_o(rv1), .rsp_ready_i(rsp_ready && sel),
        .rsp_rdata_o(rd1), .rsp_err_o(er1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full transaction: model update + push, accept, latency, hold, release.
    task automatic xact(input bit c, input logic [15:0] a, input logic [7:0] m,
                        input logic [63:0] wd, input int hold);
        int   nb, n, lat;
        bit   rdop;
        logic [15:0] base;
        exp_t e;
        nb    = c ? 8 : 4;
        lat   = c ? 4 : 1;
        rdop  = 1'b1;
        e.err   = (a >= 16'h1000);
        e.rdata = '0;
        for (int b = 0; b < nb; b++) if (m[b]) rdop = 1'b0;
        base = a & ~16'(nb - 1);
        if (!e.err) begin
            for (int b = 0; b < nb; b++) begin
                if (m[b])      mdl[c][int'(base) + b] = wd[8*b +: 8];
                else if (rdop) e.rdata[8*b +: 8] = mdl[c][int'(base) + b];
            end
        end
        q.push_back(e);

        @(negedge clk);
        sel = c; addr = a; mask = m; wdata = wd; req_valid = 1'b1; rsp_ready = 1'b0;
        #1 chk("rdy_idle", 64'(rdy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        n = 1;
        while (!rv && n < 40) begin
            chk("rdy_busy", 64'(rdy), 64'd0);
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(lat));
        e = q.pop_front();
        chk("rsp_data", rd, e.rdata);
        chk("rsp_err", 64'(er), 64'(e.err));
        chk("rdy_resp", 64'(rdy), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_v", 64'(rv), 64'd1);
            chk("hold_d", rd, e.rdata);
            chk("hold_e", 64'(er), 64'(e.err));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("done_v", 64'(rv), 64'd0);
        chk("done_rdy", 64'(rdy), 64'd1);
        chk("done_d", rd, 64'd0);
        chk("done_e", 64'(er), 64'd0);
        rsp_ready = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rdy"}, 64'(rdy), 64'd1);
        chk({tag, "_v"}, 64'(rv), 64'd0);
        chk({tag, "_d"}, rd, 64'd0);
        chk({tag, "_e"}, 64'(er), 64'd0);
    endtask

    initial begin
        sel = 1'b0; req_valid = 1'b0; addr = '0; mask = '0; wdata = '0; rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sel = 1'b0; #1 chk_idle("rst0");
        sel = 1'b1; #1 chk_idle("rst1");
        rst_n = 1'b1;
        @(negedge clk);

        // 32-bit, LATENCY=0
        xact(1'b0, 16'h0010, 8'h0F, 64'hDEADBEEF, 0);
        xact(1'b0, 16'h0010, 8'h00, 64'h0, 0);
        xact(1'b0, 16'h0010, 8'h05, 64'h11223344, 0);
        xact(1'b0, 16'h0013, 8'h00, 64'h0, 5);
        chk("merge_const", {32'h0, mdl[0][19], mdl[0][18], mdl[0][17], mdl[0][16]}, 64'hDE22BE44);
        xact(1'b0, 16'h0000, 8'h0F, 64'hCAFEF00D, 0);
        xact(1'b0, 16'h1000, 8'h0F, 64'hFFFFFFFF, 0);
        xact(1'b0, 16'h0000, 8'h00, 64'h0, 0);
        xact(1'b0, 16'hFFFC, 8'h00, 64'h0, 2);

        // 64-bit, LATENCY=3
        xact(1'b1, 16'h0010, 8'hFF, 64'h0123456789ABCDEF, 0);
        xact(1'b1, 16'h0010, 8'h00, 64'h0, 0);
        xact(1'b1, 16'h0010, 8'hA5, 64'hFFEEDDCCBBAA9988, 0);
        xact(1'b1, 16'h0017, 8'h00, 64'h0, 5);
        xact(1'b1, 16'h1008, 8'hFF, 64'h5555AAAA5555AAAA, 0);

        // Reset while in WAIT
        @(negedge clk);
        sel = 1'b1; addr = 16'h0010; mask = 8'h00; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("wait_v", 64'(rv), 64'd0);
        chk("wait_rdy", 64'(rdy), 64'd0);
        rst_n = 1'b0;
        #1 chk_idle("rstw");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while in RESP: valid must drop without a clock edge
        addr = 16'h0010; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("resp_v", 64'(rv), 64'd1);
        rst_n = 1'b0;
        #1 chk_idle("rstr");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xact(1'b1, 16'h0010, 8'h00, 64'h0, 0);
        xact(1'b0, 16'h0010, 8'h00, 64'h0, 0);

        // Fill a small window, then random mixed traffic
        for (int w = 0; w < 8; w++) begin
            xact(1'b0, 16'(w * 4), 8'h0F, {32'h0, $urandom}, 0);
            xact(1'b1, 16'(w * 8), 8'hFF, {$urandom, $urandom}, 0);
        end
        for (int i = 0; i < 24; i++) begin
            bit          c;
            logic [15:0] a;
            logic [7:0]  m;
            c = 1'($urandom_range(0, 1));
            a = 16'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | 16'h1000;
            m = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            xact(c, a, m, {$urandom, $urandom}, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
